// File: rtl/wide_lane_mem.sv
// rtl/wide_lane_mem.sv - word memory with wide lane-enabled write port, wide registered read port and reset-driven clear (optional WIDE_LANE_MEM_WR_BYPASS_EN)
module wide_lane_mem #(
  parameter int               WORD_W   = 8,
  parameter int               WR_LANES = 4,
  parameter int               RD_LANES = 2,
  parameter int               DEPTH    = 256,
  parameter logic [WORD_W-1:0] INIT_VAL = '0
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [WR_LANES-1:0]                 we,
  input  logic [$clog2(DEPTH/WR_LANES)-1:0]   wa,
  input  logic [WR_LANES*WORD_W-1:0]          wd,
  input  logic                                re,
  input  logic [$clog2(DEPTH/RD_LANES)-1:0]   ra,
  output logic [RD_LANES*WORD_W-1:0]          rd,
  output logic                                rd_valid,
  output logic                                busy
);

  localparam int ROWS = DEPTH / WR_LANES;
  localparam int WA_W = $clog2(ROWS);
  localparam int AW   = $clog2(DEPTH);

  typedef enum logic {CLEAR, READY} state_t;

  state_t                        state;
  logic [WA_W-1:0]               clr_row;
  logic [WORD_W-1:0]             mem [DEPTH];

  logic [WA_W-1:0]               wr_row;
  logic [WR_LANES-1:0]           wr_en;
  logic [WR_LANES*WORD_W-1:0]    wr_data;
  logic [RD_LANES*WORD_W-1:0]    rd_next;

  // Single write path shared by the clear sequencer and user writes; nothing is written on a reset edge
  always_comb begin
    wr_row  = wa;
    wr_en   = '0;
    wr_data = wd;
    if (!rst) begin
      if (state == CLEAR) begin
        wr_row  = clr_row;
        wr_en   = '1;
        wr_data = {WR_LANES{INIT_VAL}};
      end else begin
        wr_en = we;
      end
    end
  end

  // Storage array: per-lane word writes into the selected row
  always_ff @(posedge clk) begin
    for (int i = 0; i < WR_LANES; i++) begin
      if (wr_en[i]) begin
        mem[AW'(wr_row) * AW'(WR_LANES) + AW'(i)] <= wr_data[i*WORD_W +: WORD_W];
      end
    end
  end

  // Read data ahead of the output register; old contents unless write-first forwarding is built in
  always_comb begin
    rd_next = '0;
    for (int j = 0; j < RD_LANES; j++) begin
      rd_next[j*WORD_W +: WORD_W] = mem[AW'(ra) * AW'(RD_LANES) + AW'(j)];
`ifdef WIDE_LANE_MEM_WR_BYPASS_EN
      for (int i = 0; i < WR_LANES; i++) begin
        if (we[i] && (AW'(wa) * AW'(WR_LANES) + AW'(i) == AW'(ra) * AW'(RD_LANES) + AW'(j))) begin
          rd_next[j*WORD_W +: WORD_W] = wd[i*WORD_W +: WORD_W];
        end
      end
`endif
    end
  end

  // Clear sequencer and registered read port; requests only take effect once READY
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= CLEAR;
      clr_row  <= '0;
      busy     <= 1'b1;
      rd       <= '0;
      rd_valid <= 1'b0;
    end else begin
      case (state)
        CLEAR: begin
          rd_valid <= 1'b0;
          clr_row  <= clr_row + WA_W'(1);
          if (clr_row == WA_W'(ROWS - 1)) begin
            state <= READY;
            busy  <= 1'b0;
          end
        end
        READY: begin
          rd_valid <= re;
          if (re) begin
            rd <= rd_next;
          end
        end
        default: begin
          state <= CLEAR;
          busy  <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wide_lane_mem.sv
// tb/tb_wide_lane_mem.sv - randomized self-checking bench for wide_lane_mem against a word-array reference model
module tb_wide_lane_mem;

  localparam int WORD_W   = 8;
  localparam int WR_LANES = 4;
  localparam int RD_LANES = 2;
  localparam int DEPTH    = 256;
  localparam int ROWS     = DEPTH / WR_LANES;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  we;
  logic [5:0]  wa;
  logic [31:0] wd;
  logic        re;
  logic [6:0]  ra;
  logic [15:0] rd;
  logic        rd_valid;
  logic        busy;

  int n_cmp = 0;
  int n_bad = 0;

  logic [7:0]  ref_mem [DEPTH];
  int          clear_left;
  logic [15:0] exp_rd;
  logic        exp_valid;

  always #5 clk = ~clk;

  wide_lane_mem #(
    .WORD_W  (WORD_W),
    .WR_LANES(WR_LANES),
    .RD_LANES(RD_LANES),
    .DEPTH   (DEPTH),
    .INIT_VAL(8'h00)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .we      (we),
    .wa      (wa),
    .wd      (wd),
    .re      (re),
    .ra      (ra),
    .rd      (rd),
    .rd_valid(rd_valid),
    .busy    (busy)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference: what the coming edge does, from the current inputs and the model's word array
  task automatic model_edge();
    if (rst) begin
      clear_left = ROWS;
      exp_rd     = '0;
      exp_valid  = 1'b0;
    end else if (clear_left > 0) begin
      clear_left--;
      exp_valid = 1'b0;
      if (clear_left == 0)
        for (int k = 0; k < DEPTH; k++) ref_mem[k] = 8'h00;
    end else begin
      exp_valid = re;
      if (re) begin
        for (int j = 0; j < RD_LANES; j++) begin
          int idx;
          logic [7:0] w;
          idx = int'(ra) * RD_LANES + j;
          w   = ref_mem[idx];
`ifdef WIDE_LANE_MEM_WR_BYPASS_EN
          if (idx / WR_LANES == int'(wa) && we[idx % WR_LANES])
            w = wd[(idx % WR_LANES)*8 +: 8];
`endif
          exp_rd[j*8 +: 8] = w;
        end
      end
      for (int i = 0; i < WR_LANES; i++)
        if (we[i]) ref_mem[int'(wa) * WR_LANES + i] = wd[i*8 +: 8];
    end
  endtask

  task automatic cyc(input string tag);
    model_edge();
    @(posedge clk);
    #1;
    check({tag, ".busy"}, {31'd0, busy}, {31'd0, clear_left > 0});
    check({tag, ".rd_valid"}, {31'd0, rd_valid}, {31'd0, exp_valid});
    check({tag, ".rd"}, {16'd0, rd}, {16'd0, exp_rd});
  endtask

  task automatic drive(input logic r, input logic [3:0] w, input logic [5:0] a,
                       input logic [31:0] d, input logic e, input logic [6:0] b);
    rst = r; we = w; wa = a; wd = d; re = e; ra = b;
  endtask

  task automatic drive_random(input int collide_pct);
    logic [5:0] a;
    a = 6'($urandom_range(0, ROWS - 1));
    if (int'($urandom_range(0, 99)) < collide_pct)
      drive(1'b0, 4'($urandom), a, $urandom, 1'b1, {a, 1'($urandom)});
    else
      drive(1'b0, 4'($urandom), a, $urandom, 1'($urandom), 7'($urandom));
  endtask

  task automatic run_clear(input string tag);
    int n;
    n = 0;
    while (busy && n < 200) begin
      if (n == 0) drive(1'b0, 4'b1111, 6'd0, 32'hFFFFFFFF, 1'b1, 7'd0);
      else        drive_random(30);
      cyc(tag);
      n++;
    end
    check({tag, ".length"}, n, ROWS);
  endtask

  task automatic read_row(input string tag, input logic [6:0] b);
    drive(1'b0, 4'b0000, 6'd0, 32'd0, 1'b1, b);
    cyc(tag);
  endtask

  initial begin
    for (int k = 0; k < DEPTH; k++) ref_mem[k] = 8'h00;
    clear_left = ROWS;
    exp_rd     = '0;
    exp_valid  = 1'b0;
    drive(1'b1, 4'b0000, 6'd0, 32'd0, 1'b0, 7'd0);

    // reset pulse, then clear with requests masked
    cyc("reset");
    check("reset.busy_const", {31'd0, busy}, 32'd1);
    run_clear("clear1");

    read_row("rd_row0", 7'd0);
    check("rd_row0.const", {16'd0, rd}, 32'h0000);
    read_row("rd_row127", 7'd127);
    check("rd_row127.const", {16'd0, rd}, 32'h0000);
    check("rd_row127.valid_const", {31'd0, rd_valid}, 32'd1);

    // full-lane write
    drive(1'b0, 4'b1111, 6'd1, 32'h78563412, 1'b0, 7'd0);
    cyc("wr_full");
    read_row("rd_full2", 7'd2);
    check("rd_full2.const", {16'd0, rd}, 32'h3412);
    read_row("rd_full3", 7'd3);
    check("rd_full3.const", {16'd0, rd}, 32'h7856);

    // partial lanes
    drive(1'b0, 4'b0101, 6'd1, 32'hAABBCCDD, 1'b0, 7'd0);
    cyc("wr_part");
    read_row("rd_part2", 7'd2);
    check("rd_part2.const", {16'd0, rd}, 32'h34DD);
    read_row("rd_part3", 7'd3);
    check("rd_part3.const", {16'd0, rd}, 32'h78BB);

    // idle cycle: rd holds, rd_valid drops
    drive(1'b0, 4'b0000, 6'd0, 32'd0, 1'b0, 7'd0);
    cyc("idle_hold");

    // collision on word 4
    drive(1'b0, 4'b0001, 6'd1, 32'h00000012, 1'b0, 7'd0);
    cyc("wr_w4");
    drive(1'b0, 4'b0001, 6'd1, 32'h00000099, 1'b1, 7'd2);
    cyc("collide");
`ifdef WIDE_LANE_MEM_WR_BYPASS_EN
    check("collide.const", {16'd0, rd}, 32'h3499);
`else
    check("collide.const", {16'd0, rd}, 32'h3412);
`endif
    read_row("after_collide", 7'd2);
    check("after_collide.const", {24'd0, rd[7:0]}, 32'h99);

    // randomized traffic with frequent overlap
    for (int c = 0; c < 1500; c++) begin
      drive_random(40);
      cyc("rand1");
    end

    // reset in READY with a read pending
    drive(1'b1, 4'b1111, 6'd3, $urandom, 1'b1, 7'd6);
    cyc("rst_ready");
    check("rst_ready.valid_const", {31'd0, rd_valid}, 32'd0);

    // reset mid-clear at cycle 30
    for (int c = 0; c < 30; c++) begin
      drive_random(30);
      cyc("clear2");
    end
    drive(1'b1, 4'b0000, 6'd0, 32'd0, 1'b1, 7'd0);
    cyc("rst_mid");
    run_clear("clear3");

    for (int c = 0; c < 1500; c++) begin
      drive_random(40);
      cyc("rand2");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
